global_stall_ctrl: RTL

- Central stall/flush sequencer for the global-stall pipeline.
- Collects buffer-full flags from every stage's skid buffer, plus a downstream stall request and a flush request.
- Drives a single registered global stall and flush to all stage buffers.
- Enforces a minimum stall hold, a one-cycle release window and a multi-cycle flush, and flags stuck stalls via a watchdog.

---
 rtl/global_stall_ctrl_pkg.sv | 34 +++
 rtl/global_stall_ctrl_if.sv | 52 +++++
 rtl/global_stall_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/global_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_pkg
// Shared definitions for the global stall/flush sequencer:
//   - stall_state_t : 2-bit FSM state (RUN=0, STALL=1, RELEASE=2, FLUSH=3)
//   - STALL_CNT_W   : width of the consecutive-stall counter
//   - PERF_W        : width of the optional stall-cycle performance counter
//   - PERF_FLUSH_W  : width of the optional flush-entry performance counter
//   - sat_inc_cnt() : saturating increment for STALL_CNT_W-wide counters
// -----------------------------------------------------------------------------
package stall_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_STALL   = 2'd1,
      ST_RELEASE = 2'd2,
      ST_FLUSH   = 2'd3
   } stall_state_t;

   localparam int STALL_CNT_W  = 16;
   localparam int PERF_W       = 32;
   localparam int PERF_FLUSH_W = 16;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [STALL_CNT_W-1:0] sat_inc_cnt(input logic [STALL_CNT_W-1:0] v);
      logic [STALL_CNT_W-1:0] r;
      if (v == {STALL_CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/global_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// global_stall_ctrl_if
// Bundles the stall-control bus between the central sequencer and the stages.
//   buf_full[NUM_STAGES-1:0] : per-stage skid buffer full flags (stages -> ctrl)
//   ds_stall_req             : downstream not ready                (-> ctrl)
//   flush_req                : flush request, level sampled        (-> ctrl)
//   stall_out / flush_out    : global stall / flush                (ctrl ->)
//   state_out[1:0]           : sequencer state encoding            (ctrl ->)
//   timeout                  : sticky stuck-stall flag             (ctrl ->)
//   stall_cnt[15:0]          : consecutive STALL cycles, saturating (ctrl ->)
//   perf_stall_total / perf_flush_total : only with STALL_PERF_CNT_EN defined
// Modports: master = the sequencer, slave = the stages / environment.
// -----------------------------------------------------------------------------
interface global_stall_ctrl_if #(
   parameter int NUM_STAGES = 4
);
   import stall_pkg::*;

   logic [NUM_STAGES-1:0]  buf_full;
   logic                   ds_stall_req;
   logic                   flush_req;
   logic                   stall_out;
   logic                   flush_out;
   logic [1:0]             state_out;
   logic                   timeout;
   logic [STALL_CNT_W-1:0] stall_cnt;
`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0]       perf_stall_total;
   logic [PERF_FLUSH_W-1:0] perf_flush_total;

   modport master (
      input  buf_full, ds_stall_req, flush_req,
      output stall_out, flush_out, state_out, timeout, stall_cnt,
      output perf_stall_total, perf_flush_total
   );
   modport slave (
      output buf_full, ds_stall_req, flush_req,
      input  stall_out, flush_out, state_out, timeout, stall_cnt,
      input  perf_stall_total, perf_flush_total
   );
`else
   modport master (
      input  buf_full, ds_stall_req, flush_req,
      output stall_out, flush_out, state_out, timeout, stall_cnt
   );
   modport slave (
      output buf_full, ds_stall_req, flush_req,
      input  stall_out, flush_out, state_out, timeout, stall_cnt
   );
`endif

endinterface

// File: rtl/global_stall_ctrl.sv
// -----------------------------------------------------------------------------
// global_stall_ctrl
// Central stall/flush sequencer. Collects buffer-full flags and a downstream
// stall request, and drives one registered global stall and flush. Enforces a
// minimum stall hold, a one-cycle release window that lets buffers drain one
// entry, and a multi-cycle (extendable) flush. A watchdog flags stuck stalls.
//
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : global_stall_ctrl_if.master (see interface for signal list)
//
// Optional feature: define STALL_PERF_CNT_EN to add the saturating
// perf_stall_total / perf_flush_total counters (cleared only by reset).
// -----------------------------------------------------------------------------
module global_stall_ctrl
   import stall_pkg::*;
#(
   parameter int NUM_STAGES   = 4,
   parameter int MIN_STALL    = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int WDOG_LIMIT   = 255
) (
   input  logic                clk,
   input  logic                reset,
   global_stall_ctrl_if.master bus
);

   localparam int HOLD_W  = (MIN_STALL > 1)    ? $clog2(MIN_STALL)    : 1;
   localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(MIN_STALL - 1);
   localparam logic [FLUSH_W-1:0]     FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
   localparam logic [STALL_CNT_W-1:0] WDOG_CNT   = STALL_CNT_W'(WDOG_LIMIT);

   logic [NUM_STAGES-1:0]  buf_full_s;
   logic                   stall_cause_s;
   stall_state_t           state_r;
   stall_state_t           state_nxt_s;
   logic                   stall_out_r;
   logic                   flush_out_r;
   logic [HOLD_W-1:0]      hold_r;
   logic [FLUSH_W-1:0]     flush_cnt_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;
   logic [STALL_CNT_W-1:0] stall_cnt_nxt_s;
   logic                   timeout_r;

   assign buf_full_s    = bus.buf_full;
   assign stall_cause_s = (|buf_full_s) | bus.ds_stall_req;

   // Next-state decision; flush_req overrides every state.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.flush_req) begin
         state_nxt_s = ST_FLUSH;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (stall_cause_s) begin
                  state_nxt_s = ST_STALL;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_STALL: begin
               if (!stall_cause_s && (hold_r >= HOLD_LAST)) begin
                  state_nxt_s = ST_RELEASE;
               end else begin
                  state_nxt_s = ST_STALL;
               end
            end
            // buf_full is stale here (buffers are draining), so only the
            // downstream request can bring the stall straight back.
            ST_RELEASE: begin
               if (bus.ds_stall_req) begin
                  state_nxt_s = ST_STALL;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            // Stall causes are deliberately ignored until the flush ends.
            ST_FLUSH: begin
               if (flush_cnt_r == {FLUSH_W{1'b0}}) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_FLUSH;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // State register with Moore outputs decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RUN;
         stall_out_r <= 1'b0;
         flush_out_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         stall_out_r <= (state_nxt_s == ST_STALL);
         flush_out_r <= (state_nxt_s == ST_FLUSH);
      end
   end

   // Minimum-hold counter: zero on every STALL entry, saturates at MIN_STALL-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_r <= {HOLD_W{1'b0}};
      end else if ((state_nxt_s == ST_STALL) && (state_r == ST_STALL)) begin
         if (hold_r < HOLD_LAST) begin
            hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
         end else begin
            hold_r <= hold_r;
         end
      end else begin
         hold_r <= {HOLD_W{1'b0}};
      end
   end

   // Flush length counter: loads on entry or on a repeated request, then counts down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_cnt_r <= {FLUSH_W{1'b0}};
      end else if ((state_nxt_s == ST_FLUSH) && ((state_r != ST_FLUSH) || bus.flush_req)) begin
         flush_cnt_r <= FLUSH_LOAD;
      end else if ((state_r == ST_FLUSH) && (flush_cnt_r != {FLUSH_W{1'b0}})) begin
         flush_cnt_r <= flush_cnt_r - {{(FLUSH_W-1){1'b0}}, 1'b1};
      end else begin
         flush_cnt_r <= flush_cnt_r;
      end
   end

   // Stall-cycle count; survives a RELEASE->STALL bounce, clears on RUN/FLUSH.
   always_comb begin
      stall_cnt_nxt_s = {STALL_CNT_W{1'b0}};
      case (state_nxt_s)
         ST_STALL:   stall_cnt_nxt_s = sat_inc_cnt(stall_cnt_r);
         ST_RELEASE: stall_cnt_nxt_s = stall_cnt_r;
         default:    stall_cnt_nxt_s = {STALL_CNT_W{1'b0}};
      endcase
   end

   // Stall-cycle count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else begin
         stall_cnt_r <= stall_cnt_nxt_s;
      end
   end

   // Sticky watchdog flag; entering FLUSH clears it and wins over a set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_r <= 1'b0;
      end else if (state_nxt_s == ST_FLUSH) begin
         timeout_r <= 1'b0;
      end else if (stall_cnt_nxt_s == WDOG_CNT) begin
         timeout_r <= 1'b1;
      end else begin
         timeout_r <= timeout_r;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0]       perf_stall_r;
   logic [PERF_FLUSH_W-1:0] perf_flush_r;

   // Saturating count of all cycles with stall_out high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_r <= {PERF_W{1'b0}};
      end else if ((state_nxt_s == ST_STALL) && (perf_stall_r != {PERF_W{1'b1}})) begin
         perf_stall_r <= perf_stall_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
         perf_stall_r <= perf_stall_r;
      end
   end

   // Saturating count of FLUSH entries (extensions are not new entries).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_flush_r <= {PERF_FLUSH_W{1'b0}};
      end else if ((state_nxt_s == ST_FLUSH) && (state_r != ST_FLUSH) &&
                   (perf_flush_r != {PERF_FLUSH_W{1'b1}})) begin
         perf_flush_r <= perf_flush_r + {{(PERF_FLUSH_W-1){1'b0}}, 1'b1};
      end else begin
         perf_flush_r <= perf_flush_r;
      end
   end

   assign bus.perf_stall_total = perf_stall_r;
   assign bus.perf_flush_total = perf_flush_r;
`endif

   assign bus.stall_out = stall_out_r;
   assign bus.flush_out = flush_out_r;
   assign bus.state_out = state_r;
   assign bus.timeout   = timeout_r;
   assign bus.stall_cnt = stall_cnt_r;

endmodule
